// File: rtl/pc_sequencer.sv
// Fetch/commit sequencer: owns the PC, handshakes with instruction and data memory,
// and steers the next-PC unit. Performs no PC arithmetic of its own.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [15:0] FETCH_TIMEOUT = 16'd255
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        br_taken,
  input  logic        is_mem,
  input  logic        dmem_done,
  input  logic        halt,
  output logic [1:0]  npc_op,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_COMMIT, S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [15:0] r_tcnt;
  logic        r_fault;
  logic [15:0] w_tcnt_inc;
  logic        w_timeout;
  logic [1:0]  w_op;

  assign w_tcnt_inc = r_tcnt + 16'd1;
  assign w_timeout  = (w_tcnt_inc == FETCH_TIMEOUT);

  // Jump outranks branch; a not-taken branch falls through to sequential advance.
  assign w_op = is_jump                ? 2'b10 :
                (is_branch & br_taken) ? 2'b01 : 2'b00;

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign fault     = r_fault;

  always_comb begin
    w_next      = r_state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    npc_op      = 2'b00;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready)     w_next = S_EXEC;
        else if (w_timeout) w_next = S_HALT;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        npc_op      = w_op;
        if (halt) begin
          retire = 1'b1;
          w_next = S_HALT;
        end else begin
          w_next = is_mem ? S_MEM : S_COMMIT;
        end
      end
      S_MEM: begin
        npc_op = w_op;
        if (dmem_done) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        npc_op = w_op;
        retire = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_tcnt  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        if (imem_ready) begin
          r_instr <= imem_rdata;
          r_tcnt  <= '0;
        end else if (w_timeout) begin
          r_tcnt  <= '0;
          r_fault <= 1'b1;
        end else begin
          r_tcnt  <= w_tcnt_inc;
        end
      end
      if (r_state == S_COMMIT) r_pc <= npc;
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/commit controller that owns the program counter and sequences the next-PC unit of the RISC-V core. Each cycle it selects the next-PC operation code from decoder and ALU status, handshakes with instruction memory, waits on data memory, and commits the next-PC value into the PC register. The PC is word-indexed: sequential advance is PC+1, computed by the next-PC unit. The sequencer performs no PC arithmetic itself.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16'd255, maximum FETCH cycles without imem_ready before fault; legal range 1..65535.

- clk  in  1  core clock; all state changes on rising edge.
- rstn  in  1  synchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  instruction register.
- instr_valid  out  1  one-cycle pulse in the first EXEC cycle.
- is_branch  in  1  decoded conditional branch.
- is_jump  in  1  decoded jal/jalr; ALU output is the target.
- br_taken  in  1  branch condition true, from ALU compare.
- is_mem  in  1  decoded load/store.
- dmem_done  in  1  data memory access complete.
- halt  in  1  decoded ecall/ebreak.
- npc_op  out  2  next-PC op: 2'b00 = PLUS4 (PC+1), 2'b01 = BRANCH, 2'b10 = JUMP.
- npc  in  32  next-PC unit result.
- pc  out  32  program counter register.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  sequencer in HALT.
- fault  out  1  sticky; set on fetch timeout.

## Operation
- States: IDLE, FETCH, EXEC, MEM, COMMIT, HALT. Encoding is free. No other states exist.
- IDLE: one cycle after reset release, then → FETCH.
- FETCH:
  - imem_req=1.
  - imem_ready=1 → latch instr<=imem_rdata, clear the timeout counter, → EXEC.
  - Otherwise increment the timeout counter. Counter reaching FETCH_TIMEOUT → HALT with fault<=1.
- EXEC:
  - instr_valid=1.
  - halt=1 → HALT, retire=1, pc unchanged; halt has priority over all other inputs.
  - Otherwise is_mem=1 → MEM, else → COMMIT.
- MEM: hold until dmem_done=1, then → COMMIT. There is no timeout.
- COMMIT: pc<=npc, retire=1, → FETCH.
- npc_op is driven combinationally in EXEC, MEM and COMMIT:
  - is_jump=1 → 2'b10, including when is_branch is also 1.
  - else is_branch=1 and br_taken=1 → 2'b01.
  - else 2'b00.
  - In IDLE, FETCH and HALT, npc_op=2'b00.
- HALT: absorbing state; only rstn exits it. imem_req=0, halted=1.
- imem_ready outside FETCH is ignored; dmem_done outside MEM is ignored.
- npc is loaded verbatim. Wrap-around (e.g. 32'hFFFF_FFFF → 0) is the next-PC unit's result, not corrected here.
- Decoder/ALU inputs derive from instr and must be stable from EXEC through COMMIT. The sequencer samples them only in those states.

## Timing
- Reset (rstn=0 at an edge, from any state including mid-MEM/FETCH):
  - state=IDLE, pc=RESET_PC, instr=0, timeout counter=0.
  - imem_req=0, instr_valid=0, npc_op=2'b00, retire=0, halted=0, fault=0.
- Minimum latency, non-memory instruction with imem_ready in the first FETCH cycle: FETCH, EXEC, COMMIT = 3 cycles. The new pc is visible in the cycle after COMMIT, which is the next FETCH.
- Memory instruction: 3 + N cycles, where N ≥ 1 is the number of MEM cycles up to and including the one with dmem_done=1.
- Each FETCH wait cycle adds one cycle.
- First fetch begins 2 cycles after rstn rises: IDLE, then FETCH.
- retire and instr_valid are registered-state-decoded and are never high for more than one consecutive cycle.

## Test plan
- Straight-line: RESET_PC=0, imem_ready tied 1, three ALU ops, npc=pc+1 → pc goes 0,1,2,3. retire pulses every 3 cycles. npc_op=00 throughout.
- Branch taken: pc=5, is_branch=1, br_taken=1, npc=5+{IMM}=2 → npc_op=01 in EXEC/COMMIT; pc=2 after COMMIT. Repeat with br_taken=0 → npc_op=00.
- Jump priority: is_jump=1 and is_branch=1, npc=32'h40 → npc_op=10; pc=32'h40.
- Memory wait: is_mem=1, dmem_done asserted on the 4th MEM cycle → retire exactly 7 cycles after FETCH start; pc updates once.
- Fetch timeout: FETCH_TIMEOUT=4, imem_ready held 0 → HALT after 4 FETCH cycles; fault=1, halted=1, imem_req=0; no retire.
- Reset mid-MEM: rstn=0 for one edge while in MEM → next cycle IDLE, pc=RESET_PC, fault=0. Separately, halt=1 in EXEC → halted=1 with pc unchanged and one retire pulse.
